// File: rtl/advtim_pkg.sv
// Shared types for the advanced-timer deadtime monitor: FSM states, last-side
// encoding and the default counter width.
package advtim_pkg;

    localparam int CNT_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P_ON,
        ST_N_ON,
        ST_GAP,
        ST_OVERLAP
    } dt_state_e;

    typedef enum logic [1:0] {
        SIDE_NONE,
        SIDE_P,
        SIDE_N
    } side_e;

endpackage

// File: rtl/deadtime_monitor_level_sync.sv
// Multi-flop level synchronizer for an asynchronous pin, cleared by the
// synchronous reset.
module level_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic pe_gen_clk,
    input  logic pe_gen_rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge pe_gen_clk) begin
        if (pe_gen_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/deadtime_monitor.sv
// Deadtime monitor: measures the gap between complementary P/N outputs and
// flags short gaps and shoot-through. Optional brk_req via DEADTIME_MONITOR_BRK_EN.
module deadtime_monitor
    import advtim_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             pe_gen_clk,
    input  logic             pe_gen_rst,
    input  logic             r_dme,
    input  logic             r_ccp,
    input  logic             r_ccnp,
    input  logic [CNT_W-1:0] r_dtg,
    input  logic             r_flag_clr,
    input  logic             ocp,
    input  logic             ocn,
`ifdef DEADTIME_MONITOR_BRK_EN
    output logic             brk_req,
`endif
    output logic [CNT_W-1:0] dt_meas,
    output logic             dt_meas_vld,
    output logic             dt_short_flag,
    output logic             overlap_flag
);

    logic             p_sync, n_sync;
    logic             p_act, n_act;
    logic             ovl_set;
    dt_state_e        state_q, state_d;
    side_e            last_q, last_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             meas_evt;
    logic [CNT_W-1:0] meas_val;
    logic             meas_vld_p1;
    logic [CNT_W-1:0] meas_val_p1;
    logic             meas_short_p1;

    level_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p (
        .pe_gen_clk (pe_gen_clk),
        .pe_gen_rst (pe_gen_rst),
        .d          (ocp),
        .q          (p_sync)
    );

    level_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_n (
        .pe_gen_clk (pe_gen_clk),
        .pe_gen_rst (pe_gen_rst),
        .d          (ocn),
        .q          (n_sync)
    );

    assign p_act   = p_sync ^ r_ccp;
    assign n_act   = n_sync ^ r_ccnp;
    assign ovl_set = r_dme & p_act & n_act;

    function automatic dt_state_e act_state(input logic p, input logic n);
        case ({p, n})
            2'b10:   return ST_P_ON;
            2'b01:   return ST_N_ON;
            2'b11:   return ST_OVERLAP;
            default: return ST_GAP;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gap_d    = gap_q;
        meas_evt = 1'b0;
        meas_val = '0;
        if (!r_dme) begin
            state_d = ST_IDLE;
            last_d  = SIDE_NONE;
            gap_d   = '0;
        end else if (p_act && n_act) begin
            state_d = ST_OVERLAP;
        end else begin
            case (state_q)
                ST_IDLE: state_d = act_state(p_act, n_act);
                // A direct swap to the other side is a zero-length deadtime.
                ST_P_ON: begin
                    if (!p_act) begin
                        if (n_act) begin
                            state_d  = ST_N_ON;
                            meas_evt = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            last_d  = SIDE_P;
                            gap_d   = CNT_W'(1);
                        end
                    end
                end
                ST_N_ON: begin
                    if (!n_act) begin
                        if (p_act) begin
                            state_d  = ST_P_ON;
                            meas_evt = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            last_d  = SIDE_N;
                            gap_d   = CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (p_act) begin
                        state_d  = ST_P_ON;
                        meas_evt = (last_q == SIDE_N);
                        meas_val = gap_q;
                    end else if (n_act) begin
                        state_d  = ST_N_ON;
                        meas_evt = (last_q == SIDE_P);
                        meas_val = gap_q;
                    end else if (!(&gap_q)) begin
                        gap_d = gap_q + CNT_W'(1);
                    end
                end
                ST_OVERLAP: begin
                    state_d = act_state(p_act, n_act);
                    last_d  = SIDE_NONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pe_gen_clk) begin
        if (pe_gen_rst) begin
            state_q <= ST_IDLE;
            last_q  <= SIDE_NONE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
        end
    end

    // Stage p1: capture the measurement and its threshold compare; stage p2: publish.
    always_ff @(posedge pe_gen_clk) begin
        if (pe_gen_rst) begin
            meas_vld_p1   <= 1'b0;
            meas_val_p1   <= '0;
            meas_short_p1 <= 1'b0;
            dt_meas       <= '0;
            dt_meas_vld   <= 1'b0;
            dt_short_flag <= 1'b0;
            overlap_flag  <= 1'b0;
        end else begin
            meas_vld_p1   <= meas_evt;
            meas_val_p1   <= meas_val;
            meas_short_p1 <= (meas_val < r_dtg);
            dt_meas_vld   <= meas_vld_p1;
            if (meas_vld_p1) begin
                dt_meas <= meas_val_p1;
            end
            dt_short_flag <= (meas_vld_p1 & meas_short_p1) | (dt_short_flag & ~r_flag_clr);
            overlap_flag  <= ovl_set | (overlap_flag & ~r_flag_clr);
        end
    end

`ifdef DEADTIME_MONITOR_BRK_EN
    always_ff @(posedge pe_gen_clk) begin
        if (pe_gen_rst) begin
            brk_req <= 1'b0;
        end else if (r_flag_clr) begin
            brk_req <= 1'b0;
        end else if (overlap_flag) begin
            brk_req <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/deadtime_monitor.md
DEADTIME_MONITOR -- requirements
Module: deadtime_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 10, which sets the deadtime counter, measurement and threshold width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, which sets the input synchronizer depth (legal values 2..3).
REQ-003 SHALL have port pe_gen_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port pe_gen_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port r_dme, input, 1 bit: monitor enable.
REQ-006 SHALL have port r_ccp, input, 1 bit: P output polarity (1 = active-low).
REQ-007 SHALL have port r_ccnp, input, 1 bit: N output polarity (1 = active-low).
REQ-008 SHALL have port r_dtg, input, CNT_W bits: minimum required deadtime in cycles.
REQ-009 SHALL have port r_flag_clr, input, 1 bit: single-cycle clear of the sticky flags.
REQ-010 SHALL have port ocp, input, 1 bit: observed P output pin (asynchronous).
REQ-011 SHALL have port ocn, input, 1 bit: observed N output pin (asynchronous).
REQ-012 SHALL have port dt_meas, output, CNT_W bits: last measured deadtime in cycles.
REQ-013 SHALL have port dt_meas_vld, output, 1 bit: one-cycle strobe, high when dt_meas updates.
REQ-014 SHALL have port dt_short_flag, output, 1 bit: sticky flag, a measured deadtime was below r_dtg.
REQ-015 SHALL have port overlap_flag, output, 1 bit: sticky flag, P and N were both active (shoot-through).

Function
REQ-016 SHALL compute normalized activity as p_act = sync(ocp) ^ r_ccp and n_act = sync(ocn) ^ r_ccnp, after SYNC_STAGES flops.
REQ-017 SHALL implement a state machine with states IDLE, P_ON, N_ON, GAP and OVERLAP.
REQ-018 SHALL force the FSM to IDLE, clear the gap counter and set last_side = NONE whenever r_dme = 0; flags hold their values.
REQ-019 SHALL, in IDLE with r_dme = 1, enter the state matching (p_act, n_act): 00 -> GAP, 10 -> P_ON, 01 -> N_ON, 11 -> OVERLAP; the entry into GAP from IDLE is not counted.
REQ-020 SHALL, from P_ON or N_ON, set last_side = P or N and enter GAP with gap_cnt = 1 when that side deasserts while the other side is inactive.
REQ-021 SHALL increment gap_cnt in GAP each cycle, saturating at all-ones.
REQ-022 SHALL, on leaving GAP because the side opposite last_side asserts, load dt_meas = gap_cnt and pulse dt_meas_vld one cycle later.
REQ-023 SHALL set dt_short_flag in that same update when gap_cnt < r_dtg.
REQ-024 SHALL NOT measure when the same side as last_side reasserts, or when last_side = NONE.
REQ-025 SHALL treat a direct P_ON<->N_ON swap within one cycle as a measurement of 0, setting dt_short_flag if r_dtg != 0.
REQ-026 SHALL enter OVERLAP and set overlap_flag from any enabled state whenever p_act & n_act = 1.
REQ-027 SHALL leave OVERLAP to P_ON, N_ON or GAP when at most one side is active, with last_side = NONE.
REQ-028 SHALL make r_flag_clr clear both sticky flags, except that a set event in the same cycle wins.
REQ-029 SHALL have a latency from a pin edge to dt_meas_vld of SYNC_STAGES + 2 cycles.
REQ-030 SHALL sample r_dtg at measurement time, so a change mid-gap applies to the current gap.

Reset
REQ-031 SHALL, on pe_gen_rst = 1, reset: FSM = IDLE, last_side = NONE, gap_cnt = 0, dt_meas = 0, dt_meas_vld = 0, flags = 0, synchronizer flops = 0.
REQ-032 SHALL treat reset asserted mid-gap as discarding the measurement in progress; no strobe follows.

Configuration
REQ-033 SHALL, with macro DEADTIME_MONITOR_BRK_EN defined, add output brk_req (1 bit), registered, set one cycle after overlap_flag is set and held until r_flag_clr or reset.
REQ-034 SHALL, without DEADTIME_MONITOR_BRK_EN, omit the brk_req port and its logic, with all other behaviour identical.

Structure
REQ-035 SHALL place the FSM state enum, the last_side encoding (NONE/P/N) and the CNT_W default in shared package advtim_pkg.
REQ-036 SHALL implement the synchronizer as sub-module level_sync, parameterized by SYNC_STAGES and instantiated twice (P and N).

Verification
REQ-037 SHALL verify r_dtg = 8, polarity 0: P falls, N rises 10 cycles later -> dt_meas = 10, dt_meas_vld pulses once, no flags.
REQ-038 SHALL verify r_dtg = 8: gap of 5 cycles P->N -> dt_meas = 5, dt_short_flag = 1, which stays set until r_flag_clr.
REQ-039 SHALL verify that P and N are both active for 3 cycles -> overlap_flag = 1; with DEADTIME_MONITOR_BRK_EN, brk_req = 1 one cycle later.
REQ-040 SHALL verify that P falls and P rises again after 20 cycles -> no dt_meas_vld, dt_meas unchanged.
REQ-041 SHALL verify r_ccp = r_ccnp = 1 (inverted pins), gap 12, r_dtg = 12 -> dt_meas = 12, no short flag.
REQ-042 SHALL verify r_dme dropped mid-gap, then re-enabled -> FSM IDLE, and the first commutation after re-enable is not measured.
